// File: rtl/exc_sequencer.sv
// Exception entry/return sequencer for CP0: arbitrates traps and masked interrupts,
// waits for an instruction boundary, redirects to the handler and sequences ERET.
// Debug outputs: state_o encodes IDLE=0, ARM=1, ENTER=2, HANDLER=3, EXIT=4; trap_pend_o is the pending-trap flag.
module exc_sequencer #(
    parameter int unsigned NIRQ      = 6,
    parameter logic [31:0] VEC_BASE  = 32'h0000_0180,
    parameter logic [31:0] VEC_ALT   = 32'h0000_0200,
    parameter logic [4:0]  CODE_INT  = 5'b00000,
    parameter logic [4:0]  CODE_TRAP = 5'b01101
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [NIRQ-1:0] irq_i,
    input  logic [NIRQ-1:0] irq_mask_i,
    input  logic            ie_i,
    input  logic            iv_i,
    input  logic            trap_i,
    input  logic            trap_en_i,
    input  logic            commit_i,
    input  logic [31:0]     pcp4_i,
    input  logic            eret_i,
    output logic            exl_o,
    output logic            redirect_o,
    output logic [31:0]     redirect_pc_o,
    output logic            flush_o,
    output logic [31:0]     epc_o,
    output logic [4:0]      exc_code_o,
    output logic [2:0]      irq_id_o,
    output logic [NIRQ-1:0] irq_ack_o,
    output logic [2:0]      state_o,
    output logic            trap_pend_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_ENTER   = 3'd2,
        S_HANDLER = 3'd3,
        S_EXIT    = 3'd4
    } state_e;

    state_e          state_q;
    logic            trap_pend_q, trap_pend_d;
    logic            exl_q, redirect_q, flush_q;
    logic [NIRQ-1:0] irq_ack_q;
    logic [31:0]     epc_q;
    logic [4:0]      exc_code_q;
    logic [2:0]      irq_id_q;
    logic [31:0]     rpc_q, rpc_d;

    logic [NIRQ-1:0] elig;
    logic [2:0]      win_idx;
    logic [NIRQ-1:0] win_onehot;
    logic            req;
    logic            capture_trap;

    // Lowest-index eligible line wins among interrupts; scanning downward leaves the lowest.
    always_comb begin
        elig    = irq_i & irq_mask_i & {NIRQ{ie_i}};
        win_idx = 3'd0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (elig[i]) begin
                win_idx = 3'(i);
            end
        end
        win_onehot = {{(NIRQ-1){1'b0}}, 1'b1} << win_idx;
        req        = trap_pend_q | (|elig);
    end

    // A pulse arriving in the capture cycle re-arms the flag (set wins over clear).
    always_comb begin
        capture_trap = (state_q == S_ARM) && commit_i && trap_pend_q;
        trap_pend_d  = (trap_i & trap_en_i) | (trap_pend_q & ~capture_trap);
    end

    // ENTER targets the vector chosen by the iv of that very cycle; otherwise the last target holds.
    always_comb begin
        rpc_d = rpc_q;
        case (state_q)
            S_ENTER: rpc_d = iv_i ? VEC_ALT : VEC_BASE;
            S_EXIT:  rpc_d = epc_q;
            default: rpc_d = rpc_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            trap_pend_q <= 1'b0;
            exl_q       <= 1'b0;
            redirect_q  <= 1'b0;
            flush_q     <= 1'b0;
            irq_ack_q   <= '0;
            epc_q       <= 32'h0;
            exc_code_q  <= 5'b0;
            irq_id_q    <= 3'b0;
            rpc_q       <= 32'h0;
        end else begin
            trap_pend_q <= trap_pend_d;
            rpc_q       <= rpc_d;
            redirect_q  <= 1'b0;
            flush_q     <= 1'b0;
            irq_ack_q   <= '0;
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        state_q <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (!req) begin
                        state_q <= S_IDLE;
                    end else if (commit_i) begin
                        epc_q <= pcp4_i;
                        if (trap_pend_q) begin
                            exc_code_q <= CODE_TRAP;
                        end else begin
                            exc_code_q <= CODE_INT;
                            irq_id_q   <= win_idx;
                            irq_ack_q  <= win_onehot;
                        end
                        redirect_q <= 1'b1;
                        flush_q    <= 1'b1;
                        exl_q      <= 1'b1;
                        state_q    <= S_ENTER;
                    end
                end
                S_ENTER: begin
                    state_q <= S_HANDLER;
                end
                S_HANDLER: begin
                    if (eret_i) begin
                        redirect_q <= 1'b1;
                        flush_q    <= 1'b1;
                        state_q    <= S_EXIT;
                    end
                end
                S_EXIT: begin
                    exl_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    exl_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign exl_o         = exl_q;
    assign redirect_o    = redirect_q;
    assign flush_o       = flush_q;
    assign redirect_pc_o = rpc_d;
    assign epc_o         = epc_q;
    assign exc_code_o    = exc_code_q;
    assign irq_id_o      = irq_id_q;
    assign irq_ack_o     = irq_ack_q;
    assign state_o       = state_q;
    assign trap_pend_o   = trap_pend_q;

endmodule

// File: tb/tb_exc_sequencer.sv
// Bench for exc_sequencer: scripted cycle table, hand-written corner sequences,
// then random stimulus against a transaction-level reference model.
module tb_exc_sequencer;

    localparam logic [31:0] VB = 32'h0000_0180;
    localparam logic [31:0] VA = 32'h0000_0200;
    localparam logic [4:0]  CI = 5'b00000;
    localparam logic [4:0]  CT = 5'b01101;
    localparam logic [2:0]  ST_IDLE = 3'd0, ST_ARM = 3'd1, ST_ENTER = 3'd2, ST_HANDLER = 3'd3, ST_EXIT = 3'd4;
    localparam logic [31:0] P1 = 32'h0040_0010, P2 = 32'h0040_0020, P3 = 32'h0040_0030;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic [5:0]  irq = '0, irq_mask = 6'h3F;
    logic        ie = 1'b1, iv = 1'b0, trap = 1'b0, trap_en = 1'b0, commit = 1'b0, eret = 1'b0;
    logic [31:0] pcp4 = '0;
    logic        exl, redirect, flush, trap_pend;
    logic [31:0] redirect_pc, epc;
    logic [4:0]  exc_code;
    logic [2:0]  irq_id, state;
    logic [5:0]  irq_ack;

    exc_sequencer dut (
        .clk_i(clk), .rst_i(rst), .irq_i(irq), .irq_mask_i(irq_mask), .ie_i(ie), .iv_i(iv),
        .trap_i(trap), .trap_en_i(trap_en), .commit_i(commit), .pcp4_i(pcp4), .eret_i(eret),
        .exl_o(exl), .redirect_o(redirect), .redirect_pc_o(redirect_pc), .flush_o(flush),
        .epc_o(epc), .exc_code_o(exc_code), .irq_id_o(irq_id), .irq_ack_o(irq_ack),
        .state_o(state), .trap_pend_o(trap_pend)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // One row = inputs held for one cycle + outputs expected during that cycle.
    typedef struct {
        logic        rst;
        logic [5:0]  irq;
        logic        trap, trap_en, commit;
        logic [31:0] pcp4;
        logic        eret, iv, do_chk;
        logic        exl, red;
        logic [31:0] rpc, epc;
        logic [4:0]  code;
        logic [2:0]  id;
        logic [5:0]  ack;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic [5:0] q, logic t, logic te, logic c, logic [31:0] p,
                                logic e, logic v, logic dc, logic x, logic rd, logic [31:0] rp,
                                logic [31:0] ep, logic [4:0] cd, logic [2:0] id, logic [5:0] ak);
        vec_t o;
        o.rst = r; o.irq = q; o.trap = t; o.trap_en = te; o.commit = c; o.pcp4 = p;
        o.eret = e; o.iv = v; o.do_chk = dc; o.exl = x; o.red = rd; o.rpc = rp;
        o.epc = ep; o.code = cd; o.id = id; o.ack = ak;
        return o;
    endfunction

    // Reference model: phase flags plus captured context, stepped once per clock.
    bit          m_tp, m_armed, m_enter, m_handler, m_exit;
    logic [31:0] m_epc, m_pc;
    logic [4:0]  m_code;
    logic [2:0]  m_id;
    logic [5:0]  m_ack;

    task automatic model_step();
        logic [5:0] el, iso;
        bit req, took_trap;
        if (rst) begin
            {m_tp, m_armed, m_enter, m_handler, m_exit} = '0;
            m_epc = '0; m_pc = '0; m_code = '0; m_id = '0; m_ack = '0;
            return;
        end
        el = irq & irq_mask & (ie ? 6'h3F : 6'h00);
        req = m_tp || (el != 6'h00);
        took_trap = 0;
        if (m_enter) begin
            m_enter = 0; m_handler = 1; m_pc = iv ? VA : VB;
        end else if (m_exit) begin
            m_exit = 0; m_pc = m_epc;
        end else if (m_handler) begin
            if (eret) begin m_handler = 0; m_exit = 1; end
        end else if (m_armed) begin
            m_armed = req && !commit;
            if (req && commit) begin
                m_epc = pcp4;
                if (m_tp) begin
                    m_code = CT; m_ack = '0; took_trap = 1;
                end else begin
                    iso = el & (~el + 6'd1);
                    m_code = CI; m_id = 3'($clog2(iso)); m_ack = iso;
                end
                m_enter = 1;
            end
        end else if (req) begin
            m_armed = 1;
        end
        m_tp = (trap && trap_en) || (m_tp && !took_trap);
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        // Single interrupt, then eret in IDLE.
        tbl.push_back(mk(1, 6'h00, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0,  CI, 0, 6'h00));
        tbl.push_back(mk(0, 6'h00, 0, 0, 1, P1, 0, 0, 1, 0, 0, 0,  0,  CI, 0, 6'h00));
        tbl.push_back(mk(0, 6'h04, 0, 0, 1, P1, 0, 0, 1, 0, 0, 0,  0,  CI, 0, 6'h00));
        tbl.push_back(mk(0, 6'h04, 0, 0, 1, P1, 0, 0, 1, 0, 0, 0,  0,  CI, 0, 6'h00));
        tbl.push_back(mk(0, 6'h04, 0, 0, 1, P1, 0, 0, 1, 1, 1, VB, P1, CI, 2, 6'h04));
        tbl.push_back(mk(0, 6'h00, 0, 0, 1, P1, 0, 0, 1, 1, 0, VB, P1, CI, 2, 6'h00));
        tbl.push_back(mk(0, 6'h00, 0, 0, 1, P1, 1, 0, 1, 1, 0, VB, P1, CI, 2, 6'h00));
        tbl.push_back(mk(0, 6'h00, 0, 0, 1, P1, 0, 0, 1, 1, 1, P1, P1, CI, 2, 6'h00));
        tbl.push_back(mk(0, 6'h00, 0, 0, 1, P1, 0, 0, 1, 0, 0, P1, P1, CI, 2, 6'h00));
        tbl.push_back(mk(0, 6'h00, 0, 0, 1, P1, 1, 0, 1, 0, 0, P1, P1, CI, 2, 6'h00));
        tbl.push_back(mk(0, 6'h00, 0, 0, 1, P1, 0, 0, 1, 0, 0, P1, P1, CI, 2, 6'h00));
        // Trap and irq 3/5 together: trap first, then irq 3 after one IDLE cycle.
        tbl.push_back(mk(0, 6'h28, 1, 1, 0, P2, 0, 1, 1, 0, 0, P1, P1, CI, 2, 6'h00));
        tbl.push_back(mk(0, 6'h28, 0, 1, 1, P2, 0, 1, 1, 0, 0, P1, P1, CI, 2, 6'h00));
        tbl.push_back(mk(0, 6'h28, 0, 1, 0, P2, 0, 1, 1, 1, 1, VA, P2, CT, 2, 6'h00));
        tbl.push_back(mk(0, 6'h28, 0, 1, 0, P2, 1, 1, 1, 1, 0, VA, P2, CT, 2, 6'h00));
        tbl.push_back(mk(0, 6'h28, 0, 1, 0, P3, 0, 1, 1, 1, 1, P2, P2, CT, 2, 6'h00));
        tbl.push_back(mk(0, 6'h28, 0, 1, 1, P3, 0, 1, 1, 0, 0, P2, P2, CT, 2, 6'h00));
        tbl.push_back(mk(0, 6'h28, 0, 1, 1, P3, 0, 1, 1, 0, 0, P2, P2, CT, 2, 6'h00));
        tbl.push_back(mk(0, 6'h28, 0, 1, 1, P3, 0, 1, 1, 1, 1, VA, P3, CI, 3, 6'h08));
        tbl.push_back(mk(0, 6'h00, 0, 1, 0, P3, 1, 1, 1, 1, 0, VA, P3, CI, 3, 6'h00));
        tbl.push_back(mk(0, 6'h00, 0, 1, 0, P3, 0, 1, 1, 1, 1, P3, P3, CI, 3, 6'h00));
        tbl.push_back(mk(0, 6'h00, 0, 1, 0, P3, 0, 1, 1, 0, 0, P3, P3, CI, 3, 6'h00));

        for (int i = 0; i < tbl.size(); i++) begin
            cyc();
            rst = tbl[i].rst; irq = tbl[i].irq; trap = tbl[i].trap; trap_en = tbl[i].trap_en;
            commit = tbl[i].commit; pcp4 = tbl[i].pcp4; eret = tbl[i].eret; iv = tbl[i].iv;
            irq_mask = 6'h3F; ie = 1'b1;
            #1;
            if (tbl[i].do_chk) begin
                chk($sformatf("row%0d.exl", i), 64'(exl), 64'(tbl[i].exl));
                chk($sformatf("row%0d.redirect", i), 64'(redirect), 64'(tbl[i].red));
                chk($sformatf("row%0d.flush", i), 64'(flush), 64'(tbl[i].red));
                chk($sformatf("row%0d.redirect_pc", i), 64'(redirect_pc), 64'(tbl[i].rpc));
                chk($sformatf("row%0d.epc", i), 64'(epc), 64'(tbl[i].epc));
                chk($sformatf("row%0d.exc_code", i), 64'(exc_code), 64'(tbl[i].code));
                chk($sformatf("row%0d.irq_id", i), 64'(irq_id), 64'(tbl[i].id));
                chk($sformatf("row%0d.irq_ack", i), 64'(irq_ack), 64'(tbl[i].ack));
            end
        end

        // Withdrawal: irq[0] held 5 cycles without commit, then dropped.
        cyc(); irq = 6'h01; commit = 0; iv = 0; trap_en = 1; pcp4 = 32'h0040_0100; #1;
        chk("wd.idle", 64'(state), 64'(ST_IDLE));
        for (int k = 0; k < 4; k++) begin
            cyc(); #1;
            chk($sformatf("wd.arm%0d", k), 64'({state, redirect}), 64'({ST_ARM, 1'b0}));
        end
        cyc(); irq = 6'h00; #1;
        chk("wd.last_arm", 64'({state, redirect}), 64'({ST_ARM, 1'b0}));
        cyc(); #1;
        chk("wd.back_idle", 64'({state, redirect}), 64'({ST_IDLE, 1'b0}));
        chk("wd.epc_kept", 64'(epc), 64'(P3));

        // Same, but commit rises on cycle 4: epc must be that cycle's pcp4.
        cyc(); irq = 6'h01; commit = 0; pcp4 = 32'h0040_0200; #1;
        for (int k = 1; k <= 4; k++) begin
            cyc(); pcp4 = 32'h0040_0200 + 32'(4 * k); commit = (k == 4); #1;
            chk($sformatf("cw.arm%0d", k), 64'(state), 64'(ST_ARM));
        end
        cyc(); commit = 0; #1;
        chk("cw.enter", 64'({state, redirect, flush, exl}), 64'({ST_ENTER, 3'b111}));
        chk("cw.epc", 64'(epc), 64'(32'h0040_0210));
        chk("cw.ack", 64'({irq_ack, irq_id, exc_code}), 64'({6'h01, 3'd0, CI}));
        cyc(); irq = 6'h00; eret = 1; #1;
        chk("cw.handler", 64'(state), 64'(ST_HANDLER));
        cyc(); eret = 0; #1;
        chk("cw.exit", 64'({redirect, flush, exl, redirect_pc}), 64'({3'b111, 32'h0040_0210}));
        cyc(); #1;
        chk("cw.exl_fall", 64'({exl, redirect, state}), 64'({2'b00, ST_IDLE}));

        // Masking: ie=0, then mask=0, plus a trap pulse with trap_en=0.
        cyc(); ie = 0; irq = 6'h3F; commit = 1; trap = 1; trap_en = 0; #1;
        chk("mask.ie0", 64'(state), 64'(ST_IDLE));
        cyc(); trap = 0; #1;
        chk("mask.ie0_b", 64'({state, trap_pend}), 64'({ST_IDLE, 1'b0}));
        cyc(); ie = 1; irq_mask = 6'h00; #1;
        cyc(); #1;
        chk("mask.m0", 64'({state, redirect}), 64'({ST_IDLE, 1'b0}));

        // Trap during handler stays pending and is taken after EXIT + IDLE.
        cyc(); irq_mask = 6'h3F; irq = 6'h02; #1;
        cyc(); #1;
        chk("nest.arm", 64'(state), 64'(ST_ARM));
        cyc(); irq = 6'h00; #1;
        chk("nest.enter", 64'({state, irq_ack}), 64'({ST_ENTER, 6'h02}));
        cyc(); trap = 1; trap_en = 1; #1;
        cyc(); trap = 0; #1;
        chk("nest.pend", 64'({state, trap_pend}), 64'({ST_HANDLER, 1'b1}));
        cyc(); eret = 1; #1;
        cyc(); eret = 0; #1;
        chk("nest.exit", 64'(state), 64'(ST_EXIT));
        cyc(); #1;
        chk("nest.gap", 64'({state, exl, redirect}), 64'({ST_IDLE, 2'b00}));
        cyc(); #1;
        chk("nest.arm2", 64'(state), 64'(ST_ARM));
        cyc(); #1;
        chk("nest.trap_entry", 64'({redirect, exc_code, irq_ack, redirect_pc}), 64'({1'b1, CT, 6'h00, VB}));
        cyc(); #1;
        chk("nest.cleared", 64'({state, trap_pend}), 64'({ST_HANDLER, 1'b0}));

        // Reset in HANDLER with a trap pending.
        cyc(); trap = 1; #1;
        cyc(); trap = 0; #1;
        chk("rst.pre", 64'(trap_pend), 64'(1'b1));
        cyc(); rst = 1; #1;
        cyc(); rst = 0; #1;
        chk("rst.post", 64'({exl, redirect, flush, trap_pend, state}), 64'({4'b0000, ST_IDLE}));
        chk("rst.ctx", 64'({epc, exc_code, irq_id}), 64'(0));

        // Random stimulus against the reference model.
        for (int i = 0; i < 3000; i++) begin
            cyc();
            rst = (i == 0) || ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 7) == 0) irq = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 31) == 0) irq_mask = 6'($urandom_range(0, 63));
            ie = ($urandom_range(0, 9) != 0);
            iv = 1'($urandom_range(0, 1));
            trap = ($urandom_range(0, 11) == 0);
            trap_en = ($urandom_range(0, 3) != 0);
            commit = 1'($urandom_range(0, 1));
            pcp4 = $urandom();
            eret = ($urandom_range(0, 4) == 0);
            #1;
            if (i > 0) begin
                chk($sformatf("rnd%0d.ctl", i),
                    64'({exl, redirect, flush, irq_ack, exc_code, irq_id, trap_pend}),
                    64'({m_enter | m_handler | m_exit, m_enter | m_exit, m_enter | m_exit,
                         (m_enter ? m_ack : 6'h00), m_code, m_id, m_tp}));
                chk($sformatf("rnd%0d.pc", i), {redirect_pc, epc},
                    {(m_enter ? (iv ? VA : VB) : (m_exit ? m_epc : m_pc)), m_epc});
            end
            @(posedge clk);
            model_step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/exc_sequencer.md
Name: exc_sequencer

Overview:
Interrupt/trap arbiter and exception entry/return sequencer for the CP0 block. It prioritises masked hardware interrupts and ALU traps, waits for an instruction boundary, and captures the return address and cause. It redirects and flushes the pipeline to the handler vector, holds EXL while the handler runs, and sequences ERET back to the saved PC.

Parameters:
NIRQ, 6, number of hardware interrupt lines
VEC_BASE, 32'h0000_0180, handler address when iv=0
VEC_ALT, 32'h0000_0200, handler address when iv=1
CODE_INT, 5'b00000, cause code for interrupts
CODE_TRAP, 5'b01101, cause code for traps

Ports:
clk  in  1  system clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
irq  in  NIRQ  level-sensitive interrupt requests
irq_mask  in  NIRQ  per-line enable (1 = enabled)
ie  in  1  global interrupt enable
iv  in  1  vector select
trap  in  1  single-cycle trap request pulse from ALU
trap_en  in  1  trap enable; pulse ignored when 0
commit  in  1  pipeline at instruction boundary this cycle
pcp4  in  32  PC+4 of the committing instruction
eret  in  1  single-cycle exception-return pulse
exl  out  1  exception level; high from ENTER through EXIT
redirect  out  1  one-cycle PC redirect strobe
redirect_pc  out  32  redirect target, valid when redirect=1
flush  out  1  one-cycle pipeline flush, coincident with redirect
epc  out  32  captured return address
exc_code  out  5  captured cause code
irq_id  out  3  index of the serviced interrupt
irq_ack  out  NIRQ  one-hot acknowledge pulse in ENTER

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; trap_pend, exl, redirect, flush, irq_ack, epc, exc_code and irq_id all 0; redirect_pc=0. Reset overrides all states, including mid-handler.
- trap_pend: set when trap&trap_en. Cleared only when a trap is captured. If a new pulse arrives in the capture cycle, set wins and the trap stays pending.
- elig = irq & irq_mask & {NIRQ{ie}}. Priority: trap_pend first, then the lowest-index elig bit.
- Interrupts are not latched. Lines must stay asserted until irq_ack.
- FSM states: IDLE, ARM, ENTER, HANDLER, EXIT.
- IDLE: if trap_pend or |elig, go to ARM. commit in IDLE is ignored.
- ARM: the winner is re-evaluated every cycle.
  - No request remains: go to IDLE with no side effects.
  - Request present and commit=1: capture epc<=pcp4.
    - Trap winner: exc_code<=CODE_TRAP and trap_pend cleared.
    - Interrupt winner: exc_code<=CODE_INT and irq_id<=winner index.
    - Then go to ENTER.
  - Request present and commit=0: stay in ARM.
- ENTER (exactly one cycle):
  - redirect=1, flush=1, exl=1.
  - redirect_pc = iv ? VEC_ALT : VEC_BASE, using iv sampled in this cycle.
  - irq_ack = one-hot(irq_id) for an interrupt, 0 for a trap.
  - Next state: HANDLER.
- HANDLER: exl=1. New interrupts are ignored; traps still latch into trap_pend. eret=1 goes to EXIT.
- EXIT (one cycle): redirect=1, flush=1, redirect_pc=epc, exl=1. Next state: IDLE, and exl=0 from that cycle.
- Minimum one IDLE cycle between consecutive handlers.
- eret outside HANDLER is ignored. An eret arriving in ENTER is lost; software never issues it there.
- Outside ENTER/EXIT: redirect=0, flush=0, irq_ack=0, and redirect_pc holds its last value.
- epc, exc_code and irq_id hold until the next capture.
- Latency: request visible in IDLE at cycle N, commit high at N+1, then the redirect pulse is at N+2.

Test Plan:
- Single interrupt: mask=6'h3F, ie=1, irq=6'b000100 held, commit=1, pcp4=32'h0040_0010, iv=0 → redirect 2 cycles after irq rises with redirect_pc=32'h180; irq_ack=6'b000100, epc=32'h0040_0010, exc_code=0, irq_id=2, exl=1 until EXIT.
- Priority: irq=6'b101000 plus a trap pulse (trap_en=1) in the same cycle, iv=1 → trap serviced first (exc_code=5'b01101, redirect_pc=32'h200, irq_ack=0). After eret and one IDLE cycle, irq 3 is serviced (irq_ack=6'b001000).
- Commit wait / withdrawal: irq[0] asserted with commit=0 for 5 cycles, then irq deasserted → back to IDLE, no redirect, epc unchanged. Repeat but raise commit on cycle 4 → entry with epc=pcp4 of that cycle.
- Return: in HANDLER, pulse eret → one cycle with redirect=1, flush=1, redirect_pc=epc; exl falls the following cycle; eret in IDLE produces no redirect.
- Masking/nesting: ie=0 or mask bit 0 with irq high → stays IDLE. A trap pulse in HANDLER is held pending and taken after EXIT+IDLE. A trap pulse with trap_en=0 is ignored.
- Reset mid-handler: rst=1 in HANDLER → next cycle exl=0, epc=0, trap_pend=0, state IDLE; no redirect emitted.
